// File: rtl/mak8_display_pkg.sv
// Shared definitions for the display datapath.
// Contents:
//   b2b_state_t        - state encoding of the binary-to-BCD converter FSM
//   BCD_DIGITS_DEFAULT - default number of BCD digits driven to the display
//   BCD_NINES          - all-nines pattern for an 8-digit display
//   bcd_max_value()    - largest value representable in a given number of decimal digits
package mak8_display_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } b2b_state_t;

    localparam int          BCD_DIGITS_DEFAULT = 8;
    localparam logic [31:0] BCD_NINES          = 32'h9999_9999;

    // 10^digits - 1, evaluated at elaboration time. 64 bits covers up to 19 digits.
    function automatic logic [63:0] bcd_max_value(input int digits);
        logic [63:0] v;
        v = 64'd1;
        for (int i = 0; i < digits; i++) begin
            v = v * 64'd10;
        end
        return v - 64'd1;
    endfunction

endpackage

// File: rtl/bcd_dabble_adjust.sv
// Double-dabble digit correction for a single BCD nibble.
// Ports:
//   nibble_i - current BCD digit (4 bits)
//   nibble_o - nibble_i + 3 when nibble_i >= 5, otherwise nibble_i unchanged
// The +3 is a plain 4-bit add; no carry leaves the nibble.
module bcd_dabble_adjust (
    input  logic [3:0] nibble_i,
    output logic [3:0] nibble_o
);

    assign nibble_o = (nibble_i >= 4'd5) ? (nibble_i + 4'd3) : nibble_i;

endmodule

// File: rtl/bin_to_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock.
// Holds the last completed result on bcd_out so the display never sees
// intermediate conversion values.
// Ports:
//   clk      - system clock
//   rst      - asynchronous reset, active-high
//   start    - conversion request, sampled only in IDLE
//   bin_in   - unsigned binary value, captured on the accepted start edge
//   busy     - high while a conversion is running (state != IDLE)
//   done     - one-cycle pulse when bcd_out/overflow have just been updated
//   overflow - last result did not fit in BCD_DIGITS digits and was saturated
//   bcd_out  - packed BCD result, digit 0 in bits [3:0]
//
// Handshake: start is a request without a ready/ack; it is taken on any clock
// edge where busy is low, and ignored (not queued) while busy is high. done
// marks the single cycle in which a new result is first visible; since the
// block is already idle in that cycle, start may be held high for
// back-to-back conversions every BIN_WIDTH+1 cycles.
module bin_to_bcd_converter
    import mak8_display_pkg::*;
#(
    parameter int BIN_WIDTH  = 27,
    parameter int BCD_DIGITS = BCD_DIGITS_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [BIN_WIDTH-1:0]    bin_in,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic [4*BCD_DIGITS-1:0] bcd_out
);

    localparam int          BCD_W  = 4 * BCD_DIGITS;
    localparam int          CNT_W  = $clog2(BIN_WIDTH + 1);
    localparam logic [63:0] BCD_MAX = bcd_max_value(BCD_DIGITS);

    b2b_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BIN_WIDTH-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]       scratch_q, scratch_d;
    logic                   ovf_pend_q, ovf_pend_d;
    logic [BCD_W-1:0]       bcd_q, bcd_d;
    logic                   ovf_q, ovf_d;
    logic                   done_q, done_d;

    logic [BCD_W-1:0]       adjusted;
    logic [BCD_W-1:0]       shifted;
    logic                   in_overflow;

    // Per-digit +3 correction applied before every shift.
    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adjust
        bcd_dabble_adjust u_adjust (
            .nibble_i (scratch_q[4*g +: 4]),
            .nibble_o (adjusted[4*g +: 4])
        );
    end

    // {scratch, binary} shifted left by one; the scratch MSB falls off the top,
    // which only ever carries information for out-of-range inputs.
    assign shifted = (adjusted << 1) | {{(BCD_W-1){1'b0}}, bin_q[BIN_WIDTH-1]};

    assign in_overflow = ({{(64-BIN_WIDTH){1'b0}}, bin_in} > BCD_MAX);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bin_d      = bin_q;
        scratch_d  = scratch_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d      = bin_in;
                    scratch_d  = '0;
                    cnt_d      = CNT_W'(BIN_WIDTH);
                    ovf_pend_d = in_overflow;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = shifted;
                bin_d     = bin_q << 1;
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d   = ovf_pend_q ? {BCD_DIGITS{4'h9}} : shifted;
                    ovf_d   = ovf_pend_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bin_q      <= '0;
            scratch_q  <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bin_q      <= bin_d;
            scratch_q  <= scratch_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign overflow = ovf_q;
    assign bcd_out  = bcd_q;

endmodule

// File: doc/bin_to_bcd_converter.md
Name: bin_to_bcd_converter

Overview:
- Sequential double-dabble converter that turns an unsigned binary value into packed BCD, one shift per clock.
- Sits directly upstream of the seven-segment display controller and drives its 32-bit data input.
- The display then shows decimal digits instead of raw hex nibbles.
- Holds the last completed result stable so the display never shows intermediate conversion values.

Parameters:
- BIN_WIDTH, 27, width of binary input; must satisfy 1 <= BIN_WIDTH <= 32.
- BCD_DIGITS, 8, number of BCD output digits; output width is 4*BCD_DIGITS.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- start  input  1  request a conversion; sampled only in IDLE
- bin_in  input  BIN_WIDTH  unsigned binary value; captured on the accepted start edge
- busy  output  1  high while a conversion is in progress (state != IDLE)
- done  output  1  single-cycle pulse when bcd_out has just been updated
- overflow  output  1  last result saturated; updated together with bcd_out
- bcd_out  output  4*BCD_DIGITS  packed BCD; digit 0 in bits [3:0]; connects to the display data input

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: busy=0, done=0, overflow=0, bcd_out=0, state=IDLE, shift counter=0, scratch registers=0.
- Reset asserted mid-conversion aborts the conversion immediately. bcd_out returns to 0 and no done is produced.
- States: IDLE and SHIFT.
- IDLE, start=1 at edge k:
  - capture bin_in into the binary shift register;
  - clear the BCD scratch register;
  - load the counter with BIN_WIDTH;
  - capture ovf_pending = (bin_in > 10^BCD_DIGITS - 1);
  - go to SHIFT.
- IDLE, start=0: hold all state.
- SHIFT, each edge:
  - every scratch nibble >= 5 gets +3 (4-bit add, no carry between nibbles);
  - then {scratch, binary} shifts left by 1;
  - counter decrements.
- SHIFT, edge where counter == 1 (the final shift):
  - bcd_out <= post-shift scratch value, or all digits 4'h9 if ovf_pending;
  - overflow <= ovf_pending;
  - done <= 1 for exactly one cycle;
  - state <= IDLE.
- Latency: the edge sampling start is k; done is high in the cycle after edge k+BIN_WIDTH. With defaults that is 27 edges after acceptance.
- busy is high in the cycles following edges k through k+BIN_WIDTH-1, and is low during the done cycle.
- start while busy is ignored. It is not queued and bin_in is not re-captured.
- start high in the done cycle is accepted, since the block is already in IDLE. Back-to-back throughput is therefore one conversion per BIN_WIDTH+1 cycles.
- Overflow saturation: when ovf_pending is set, all nibbles are 9 and the converted value is discarded.
- With BIN_WIDTH < 4*BCD_DIGITS*log2(10)/4 overflow may be impossible. The comparison is still implemented.
- Scratch nibbles never exceed 9 after a shift for in-range inputs. Bits shifted out of the top of the scratch register are discarded; this matters only in the overflow case.
- bcd_out changes only on the done edge or on reset. Between conversions it holds its value unconditionally.

Decomposition:
- Shared package mak8_display_pkg holds:
  - typedef enum logic {IDLE, SHIFT} b2b_state_t;
  - localparam BCD_DIGITS_DEFAULT = 8;
  - localparam BCD_NINES = 32'h9999_9999.
- One combinational sub-module, bcd_dabble_adjust: input one nibble, output nibble+3 if >= 5, else unchanged. It is instantiated BCD_DIGITS times with a generate loop.
- The counter, FSM and registers stay in the top module.

Test Plan:
- bin_in=0, start pulse -> done exactly 27 edges after acceptance, bcd_out=32'h0000_0000, overflow=0; busy high for 27 cycles.
- bin_in=12_345_678 -> bcd_out=32'h1234_5678, overflow=0; bcd_out unchanged before done.
- bin_in=99_999_999 -> bcd_out=32'h9999_9999, overflow=0. Then bin_in=100_000_000 -> bcd_out=32'h9999_9999, overflow=1. Then bin_in=134_217_727 -> bcd_out=32'h9999_9999, overflow=1.
- Convert 42 (bcd_out=32'h0000_0042). Then start with bin_in=7, and during busy pulse start with bin_in=5 at cycle 10 -> one done only, bcd_out=32'h0000_0007.
- Convert 1234 (bcd_out=32'h0000_1234). Then start 5678, assert rst at cycle 12 of SHIFT -> bcd_out=0, busy=0, done never pulses. After rst drops, convert 5678 -> 32'h0000_5678.
- Back-to-back: start held high continuously with bin_in=9, then 10 -> consecutive done pulses 28 cycles apart, bcd_out=32'h0000_0009 then 32'h0000_0010.
